// File: rtl/sram_lsu_port.sv
// sram_lsu_port: load/store unit to single-port synchronous SRAM controller.
// Handles one byte/half/word access at a time. Sub-word stores use
// read-modify-write because the SRAM has no byte enables.
module sram_lsu_port #(
    parameter int ADDR_WIDTH = 15
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [31:0]           req_addr,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [31:0]           resp_rdata,
    output logic                  resp_err,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    inout  wire  [31:0]           mem_data,
    output logic                  mem_sel,
    output logic                  mem_we,
    output logic                  mem_en
);

    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_DATA,
        WR,
        RESP
    } state_t;

    state_t state, state_next;

    logic [ADDR_WIDTH-1:0] word_q;
    logic [1:0]            off_q;
    logic [1:0]            size_q;
    logic                  uns_q;
    logic [31:0]           wdata_q;
    logic                  we_q;
    logic [31:0]           old_q;

    logic                  accept;
    logic                  misaligned;
    logic [31:0]           wr_word;
    logic [31:0]           load_ext;
    logic [7:0]            byte_v;
    logic [15:0]           half_v;

    // Address bits above the SRAM word index are deliberately ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^req_addr[31:ADDR_WIDTH+2];

    assign req_ready  = rst_n & (state == IDLE);
    assign accept     = req_valid & req_ready;
    assign resp_valid = (state == RESP);
    assign mem_addr   = word_q;

    // Pins follow the state directly so a reset releases them at once.
    assign mem_sel = (state == RD_ADDR) || (state == RD_DATA) || (state == WR);
    assign mem_we  = (state == WR);
    assign mem_en  = (state == RD_DATA);

    // Controller owns the bus only while writing; SRAM drives only in RD_DATA.
    assign mem_data = (state == WR) ? wr_word : {32{1'bz}};

    // Alignment / legal-size check on the incoming request.
    always_comb begin
        misaligned = 1'b0;
        unique case (req_size)
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = req_addr[0];
            2'b10:   misaligned = (req_addr[1:0] != 2'b00);
            default: misaligned = 1'b1;
        endcase
    end

    // Write word: full store data, or old word with the addressed lane replaced.
    always_comb begin
        wr_word = old_q;
        unique case (size_q)
            2'b00:   wr_word[{off_q, 3'b000} +: 8]     = wdata_q[7:0];
            2'b01:   wr_word[{off_q[1], 4'b0000} +: 16] = wdata_q[15:0];
            default: wr_word = wdata_q;
        endcase
    end

    // Lane extraction and sign/zero extension of the word on the bus.
    always_comb begin
        byte_v   = mem_data[{off_q, 3'b000} +: 8];
        half_v   = mem_data[{off_q[1], 4'b0000} +: 16];
        load_ext = mem_data;
        unique case (size_q)
            2'b00:   load_ext = {{24{byte_v[7] & ~uns_q}}, byte_v};
            2'b01:   load_ext = {{16{half_v[15] & ~uns_q}}, half_v};
            default: load_ext = mem_data;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state sequencing.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (req_valid) begin
                    if (misaligned) begin
                        state_next = RESP;
                    end else if (req_we && (req_size == 2'b10)) begin
                        state_next = WR;
                    end else begin
                        state_next = RD_ADDR;
                    end
                end
            end
            RD_ADDR: state_next = RD_DATA;
            RD_DATA: state_next = we_q ? WR : RESP;
            WR:      state_next = RESP;
            RESP:    if (resp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Request capture, old-word capture and response registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q     <= '0;
            off_q      <= '0;
            size_q     <= '0;
            uns_q      <= 1'b0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            old_q      <= '0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            if (accept) begin
                word_q     <= req_addr[ADDR_WIDTH+1:2];
                off_q      <= req_addr[1:0];
                size_q     <= req_size;
                uns_q      <= req_unsigned;
                wdata_q    <= req_wdata;
                we_q       <= req_we;
                resp_rdata <= '0;
                resp_err   <= misaligned;
            end
            if (state == RD_DATA) begin
                if (we_q) begin
                    old_q <= mem_data;
                end else begin
                    resp_rdata <= load_ext;
                end
            end
        end
    end

endmodule

// File: tb/tb_sram_lsu_port.sv
// Directed testbench for sram_lsu_port with a behavioural synchronous SRAM.
module tb_sram_lsu_port;

    localparam int AW = 15;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_we = 1'b0;
    logic [31:0]   req_addr = '0;
    logic [1:0]    req_size = '0;
    logic          req_unsigned = 1'b0;
    logic [31:0]   req_wdata = '0;
    logic          resp_valid;
    logic          resp_ready = 1'b1;
    logic [31:0]   resp_rdata;
    logic          resp_err;
    logic [AW-1:0] mem_addr;
    wire  [31:0]   mem_data;
    logic          mem_sel;
    logic          mem_we;
    logic          mem_en;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sram_lsu_port #(.ADDR_WIDTH(AW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_addr     (req_addr),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .mem_addr     (mem_addr),
        .mem_data     (mem_data),
        .mem_sel      (mem_sel),
        .mem_we       (mem_we),
        .mem_en       (mem_en)
    );

    // Undriven bus reads as all ones.
    for (genvar gi = 0; gi < 32; gi++) begin : g_pull
        pullup pu (mem_data[gi]);
    end

    // Synchronous SRAM model.
    logic [31:0] sram [0:(1<<AW)-1];
    logic [31:0] sram_q = '0;
    assign mem_data = (mem_sel && mem_en && !mem_we) ? sram_q : {32{1'bz}};

    always @(posedge clk) begin
        if (mem_sel) begin
            if (mem_we) sram[mem_addr] = mem_data;
            else        sram_q = sram[mem_addr];
        end
    end

    // Pin activity monitor.
    int          we_cnt = 0;
    int          sel_cnt = 0;
    logic [AW-1:0] we_addr = '0;
    always @(negedge clk) begin
        if (mem_we) begin
            we_cnt = we_cnt + 1;
            we_addr = mem_addr;
        end
        if (mem_sel) sel_cnt = sel_cnt + 1;
    end

    // Issue one request with resp_ready high; lat counts edges from accept to resp_valid.
    task automatic do_req(input logic we, input logic [31:0] addr, input logic [1:0] size,
                          input logic uns, input logic [31:0] wdata,
                          output int lat, output logic [31:0] rdata, output logic err);
        int n;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_size = size;
        req_unsigned = uns; req_wdata = wdata; resp_ready = 1'b1;
        n = 0;
        while (!req_ready && n < 20) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
        if (!resp_valid) lat = -1;
        rdata = resp_rdata;
        err = resp_err;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        #3;
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_req_ready got %b exp 0", req_ready); end
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid got %b exp 0", resp_valid); end
        checks++; if ({resp_err, resp_rdata} !== 33'h0) begin errors++; $display("FAIL reset_resp got err=%b rdata=%h exp 0/0", resp_err, resp_rdata); end
        checks++; if ({mem_sel, mem_we, mem_en} !== 3'b000) begin errors++; $display("FAIL reset_pins got %b exp 000", {mem_sel, mem_we, mem_en}); end
        checks++; if (mem_addr !== '0) begin errors++; $display("FAIL reset_mem_addr got %h exp 0", mem_addr); end
        checks++; if (mem_data !== 32'hFFFF_FFFF) begin errors++; $display("FAIL reset_bus got %h exp released", mem_data); end
        @(negedge clk); rst_n = 1'b1; #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready got %b exp 1", req_ready); end
    endtask

    task automatic test_word();
        int lat; logic [31:0] rd; logic err; int wb;
        sram[4] = 32'h0;
        wb = we_cnt;
        do_req(1'b1, 32'h10, 2'b10, 1'b0, 32'hDEADBEEF, lat, rd, err);
        checks++; if (lat !== 2) begin errors++; $display("FAIL word_store_lat got %0d exp 2", lat); end
        checks++; if ({err, rd} !== 33'h0) begin errors++; $display("FAIL word_store_resp got err=%b rdata=%h exp 0/0", err, rd); end
        checks++; if (we_cnt - wb !== 1) begin errors++; $display("FAIL word_store_we_pulses got %0d exp 1", we_cnt - wb); end
        checks++; if (we_addr !== 15'd4) begin errors++; $display("FAIL word_store_we_addr got %0d exp 4", we_addr); end
        checks++; if (sram[4] !== 32'hDEADBEEF) begin errors++; $display("FAIL word_store_mem got %h exp deadbeef", sram[4]); end
        wb = we_cnt;
        do_req(1'b0, 32'h10, 2'b10, 1'b0, 32'h0, lat, rd, err);
        checks++; if (lat !== 3) begin errors++; $display("FAIL word_load_lat got %0d exp 3", lat); end
        checks++; if ({err, rd} !== {1'b0, 32'hDEADBEEF}) begin errors++; $display("FAIL word_load_resp got err=%b rdata=%h exp 0/deadbeef", err, rd); end
        checks++; if (we_cnt - wb !== 0) begin errors++; $display("FAIL word_load_we got %0d exp 0", we_cnt - wb); end
    endtask

    task automatic test_byte();
        int lat; logic [31:0] rd; logic err;
        sram[4] = 32'h11223344;
        do_req(1'b1, 32'h11, 2'b00, 1'b0, 32'h123456AA, lat, rd, err);
        checks++; if (lat !== 4) begin errors++; $display("FAIL byte_store_lat got %0d exp 4", lat); end
        checks++; if (sram[4] !== 32'h1122AA44) begin errors++; $display("FAIL byte_store_mem got %h exp 1122aa44", sram[4]); end
        do_req(1'b0, 32'h11, 2'b00, 1'b0, 32'h0, lat, rd, err);
        checks++; if (rd !== 32'hFFFFFFAA) begin errors++; $display("FAIL byte_load_signed got %h exp ffffffaa", rd); end
        do_req(1'b0, 32'h11, 2'b00, 1'b1, 32'h0, lat, rd, err);
        checks++; if (rd !== 32'h000000AA) begin errors++; $display("FAIL byte_load_unsigned got %h exp 000000aa", rd); end
        do_req(1'b0, 32'h13, 2'b00, 1'b0, 32'h0, lat, rd, err);
        checks++; if (rd !== 32'h00000011) begin errors++; $display("FAIL byte_load_top got %h exp 00000011", rd); end
    endtask

    task automatic test_half();
        int lat; logic [31:0] rd; logic err;
        sram[8] = 32'h0;
        do_req(1'b1, 32'h22, 2'b01, 1'b0, 32'hABCD8001, lat, rd, err);
        checks++; if (lat !== 4) begin errors++; $display("FAIL half_store_lat got %0d exp 4", lat); end
        checks++; if (sram[8] !== 32'h80010000) begin errors++; $display("FAIL half_store_mem got %h exp 80010000", sram[8]); end
        do_req(1'b0, 32'h22, 2'b01, 1'b0, 32'h0, lat, rd, err);
        checks++; if (rd !== 32'hFFFF8001) begin errors++; $display("FAIL half_load_signed got %h exp ffff8001", rd); end
        do_req(1'b0, 32'h22, 2'b01, 1'b1, 32'h0, lat, rd, err);
        checks++; if (rd !== 32'h00008001) begin errors++; $display("FAIL half_load_unsigned got %h exp 00008001", rd); end
        do_req(1'b0, 32'h20, 2'b01, 1'b0, 32'h0, lat, rd, err);
        checks++; if (rd !== 32'h00000000) begin errors++; $display("FAIL half_load_low got %h exp 00000000", rd); end
    endtask

    task automatic test_misaligned();
        int lat; logic [31:0] rd; logic err; int sb;
        logic [31:0] addrs [3];
        logic [1:0]  sizes [3];
        addrs[0] = 32'h06; sizes[0] = 2'b10;
        addrs[1] = 32'h03; sizes[1] = 2'b01;
        addrs[2] = 32'h00; sizes[2] = 2'b11;
        sb = sel_cnt;
        for (int i = 0; i < 3; i++) begin
            do_req(i[0], addrs[i], sizes[i], 1'b0, 32'hFFFF_FFFF, lat, rd, err);
            checks++; if (lat !== 1) begin errors++; $display("FAIL misaligned_lat[%0d] got %0d exp 1", i, lat); end
            checks++; if ({err, rd} !== {1'b1, 32'h0}) begin errors++; $display("FAIL misaligned_resp[%0d] got err=%b rdata=%h exp 1/0", i, err, rd); end
        end
        checks++; if (sel_cnt - sb !== 0) begin errors++; $display("FAIL misaligned_sel got %0d cycles exp 0", sel_cnt - sb); end
    endtask

    task automatic test_back_to_back();
        int lat; logic [31:0] rd; logic err; int n;
        sram[5] = 32'hCAFEF00D;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h14; req_size = 2'b10;
        req_unsigned = 1'b0; resp_ready = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        n = 0;
        while (!resp_valid && n < 20) begin @(posedge clk); #1; n++; end
        checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL hold_timeout got resp_valid=%b exp 1", resp_valid); end
        for (int i = 0; i < 5; i++) begin
            checks++; if ({resp_valid, req_ready, resp_rdata} !== {2'b10, 32'hCAFEF00D})
                begin errors++; $display("FAIL hold_stable[%0d] got valid=%b ready=%b rdata=%h exp 1/0/cafef00d", i, resp_valid, req_ready, resp_rdata); end
            @(posedge clk); #1;
        end
        @(negedge clk); resp_ready = 1'b1;
        @(posedge clk); #1;
        checks++; if ({resp_valid, req_ready} !== 2'b01) begin errors++; $display("FAIL hold_release got valid=%b ready=%b exp 0/1", resp_valid, req_ready); end
        do_req(1'b0, 32'h10, 2'b10, 1'b0, 32'h0, lat, rd, err);
        checks++; if ({lat == 3, rd} !== {1'b1, 32'h1122AA44}) begin errors++; $display("FAIL back_to_back got lat=%0d rdata=%h exp 3/1122aa44", lat, rd); end
    endtask

    task automatic test_reset_mid();
        int wb;
        sram[12] = 32'h55667788;
        wb = we_cnt;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h31; req_size = 2'b00;
        req_unsigned = 1'b0; req_wdata = 32'h99; resp_ready = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        checks++; if ({mem_sel, mem_we, mem_en} !== 3'b101) begin errors++; $display("FAIL mid_rd_data_pins got %b exp 101", {mem_sel, mem_we, mem_en}); end
        #1 rst_n = 1'b0;
        #1;
        checks++; if ({mem_sel, mem_we, mem_en} !== 3'b000) begin errors++; $display("FAIL mid_reset_pins got %b exp 000", {mem_sel, mem_we, mem_en}); end
        checks++; if (mem_data !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mid_reset_bus got %h exp released", mem_data); end
        checks++; if ({req_ready, resp_valid} !== 2'b00) begin errors++; $display("FAIL mid_reset_hs got ready=%b valid=%b exp 0/0", req_ready, resp_valid); end
        @(posedge clk); @(posedge clk);
        @(negedge clk); rst_n = 1'b1; #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL mid_release_ready got %b exp 1", req_ready); end
        repeat (4) @(posedge clk);
        #1;
        checks++; if (sram[12] !== 32'h55667788) begin errors++; $display("FAIL mid_mem_unchanged got %h exp 55667788", sram[12]); end
        checks++; if (we_cnt - wb !== 0) begin errors++; $display("FAIL mid_no_write got %0d exp 0", we_cnt - wb); end
    endtask

    initial begin
        test_reset();
        test_word();
        test_byte();
        test_half();
        test_misaligned();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1);
    end

endmodule
